// File: rtl/compress_handler_if.sv
// DMA read port and compressed-code stream shared by compress_handler and its neighbours.
// master = encoder side (drives address/strobe and codes), slave = RAM/link side.
interface compress_handler_if #(
  parameter int ADDR_W = 16
);
  logic [ADDR_W-1:0] ramAddress;
  logic              read_signal;
  logic [7:0]        ramDataOut;
  logic [7:0]        code;
  logic              code_valid;
  logic              code_ready;

  modport master (
    output ramAddress, read_signal, code, code_valid,
    input  ramDataOut, code_ready
  );

  modport slave (
    input  ramAddress, read_signal, code, code_valid,
    output ramDataOut, code_ready
  );
endinterface

// File: rtl/compress_handler.sv
// Run-length encoder: reads a packed MSB-first bitstream over DMA and emits one code per bit run.
// Optional COMPRESS_STATS_EN adds codeCount/byteCount statistics outputs.
module compress_handler #(
  parameter int ADDR_W  = 16,
  parameter int LEN_W   = 16,
  parameter int RD_LAT  = 1,
  parameter int MAX_RUN = 127
) (
  input  logic              clk,
  input  logic              RST,
  compress_handler_if.master bus,
  input  logic              start,
  input  logic [ADDR_W-1:0] startByte,
  input  logic [LEN_W-1:0]  numBits,
  output logic              busy,
  output logic              done
`ifdef COMPRESS_STATS_EN
  ,output logic [15:0]       codeCount
  ,output logic [ADDR_W-1:0] byteCount
`endif
);

  typedef enum logic [2:0] {IDLE, FETCH, WAIT, SCAN, EMIT, FIN} state_t;

  localparam logic [2:0] LAT_LAST = 3'(RD_LAT - 1);
  localparam logic [6:0] MAX_LEN  = 7'(MAX_RUN);

  state_t           state;
  logic [LEN_W-1:0] bitsLeft;
  logic [7:0]       shiftReg;
  logic [3:0]       bitsInByte;
  logic [2:0]       latCnt;
  logic             runBit;
  logic [6:0]       runLen;
  logic             pendBit;
  logic             pendValid;

  logic curBit;
  logic extend;

  assign curBit = shiftReg[7];
  // runLen == 0 only for the very first bit of a stream
  assign extend = (runLen == '0) || ((curBit == runBit) && (runLen < MAX_LEN));

  // NOTE: every register here is assigned with <= so all branches see pre-edge values.
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      state           <= IDLE;
      bitsLeft        <= '0;
      shiftReg        <= '0;
      bitsInByte      <= '0;
      latCnt          <= '0;
      runBit          <= 1'b0;
      runLen          <= '0;
      pendBit         <= 1'b0;
      pendValid       <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
      bus.ramAddress  <= '0;
      bus.read_signal <= 1'b0;
      bus.code        <= '0;
      bus.code_valid  <= 1'b0;
`ifdef COMPRESS_STATS_EN
      codeCount       <= '0;
      byteCount       <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
`ifdef COMPRESS_STATS_EN
            codeCount <= '0;
            byteCount <= '0;
`endif
            if (numBits == '0) begin
              done  <= 1'b1;
              state <= FIN;
            end else begin
              bitsLeft        <= numBits;
              runLen          <= '0;
              pendValid       <= 1'b0;
              busy            <= 1'b1;
              bus.ramAddress  <= startByte;
              bus.read_signal <= 1'b1;
              state           <= FETCH;
            end
          end
        end

        FETCH: begin
          bus.read_signal <= 1'b0;
          latCnt          <= '0;
          state           <= WAIT;
`ifdef COMPRESS_STATS_EN
          byteCount       <= byteCount + ADDR_W'(1);
`endif
        end

        WAIT: begin
          if (latCnt == LAT_LAST) begin
            shiftReg   <= bus.ramDataOut;
            bitsInByte <= 4'd8;
            state      <= SCAN;
          end else begin
            latCnt <= latCnt + 3'd1;
          end
        end

        SCAN: begin
          if (bitsLeft == '0) begin
            // stream ended on a run break: flush the single pending bit as its own code
            bus.code       <= {~runBit, runLen};
            bus.code_valid <= 1'b1;
            state          <= EMIT;
          end else begin
            shiftReg   <= shiftReg << 1;
            bitsLeft   <= bitsLeft - LEN_W'(1);
            bitsInByte <= bitsInByte - 4'd1;
            if (extend) begin
              runBit <= curBit;
              runLen <= runLen + 7'd1;
              if (bitsLeft == LEN_W'(1)) begin
                bus.code       <= {~curBit, runLen + 7'd1};
                bus.code_valid <= 1'b1;
                state          <= EMIT;
              end else if (bitsInByte == 4'd1) begin
                bus.ramAddress  <= bus.ramAddress + ADDR_W'(1);
                bus.read_signal <= 1'b1;
                state           <= FETCH;
              end
            end else begin
              bus.code       <= {~runBit, runLen};
              bus.code_valid <= 1'b1;
              pendBit        <= curBit;
              pendValid      <= 1'b1;
              state          <= EMIT;
            end
          end
        end

        EMIT: begin
          if (bus.code_ready) begin
            bus.code_valid <= 1'b0;
`ifdef COMPRESS_STATS_EN
            codeCount      <= codeCount + 16'd1;
`endif
            if (pendValid) begin
              runBit    <= pendBit;
              runLen    <= 7'd1;
              pendValid <= 1'b0;
              if ((bitsLeft != '0) && (bitsInByte == 4'd0)) begin
                bus.ramAddress  <= bus.ramAddress + ADDR_W'(1);
                bus.read_signal <= 1'b1;
                state           <= FETCH;
              end else begin
                state <= SCAN;
              end
            end else begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= FIN;
            end
          end
        end

        FIN: begin
          done  <= 1'b0;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_compress_handler.sv
// Scoreboard bench for compress_handler: a behavioural RLE model fills the expected-code queue,
// a negedge monitor pops and compares accepted codes and logs DMA reads.
module tb_compress_handler;
  localparam int ADDR_W    = 16;
  localparam int LEN_W     = 16;
  localparam int TB_RD_LAT = 2;
  localparam int MAX_RUN   = 127;

  logic              clk = 1'b0;
  logic              RST;
  logic              start;
  logic [ADDR_W-1:0] startByte;
  logic [LEN_W-1:0]  numBits;
  logic              busy;
  logic              done;
`ifdef COMPRESS_STATS_EN
  logic [15:0]       codeCount;
  logic [ADDR_W-1:0] byteCount;
`endif

  compress_handler_if #(.ADDR_W(ADDR_W)) bus ();

  compress_handler #(
    .ADDR_W (ADDR_W),
    .LEN_W  (LEN_W),
    .RD_LAT (TB_RD_LAT),
    .MAX_RUN(MAX_RUN)
  ) dut (
    .clk      (clk),
    .RST      (RST),
    .bus      (bus),
    .start    (start),
    .startByte(startByte),
    .numBits  (numBits),
    .busy     (busy),
    .done     (done)
`ifdef COMPRESS_STATS_EN
    ,.codeCount(codeCount)
    ,.byteCount(byteCount)
`endif
  );

  always #5 clk = ~clk;

  int nCompared   = 0;
  int nMismatched = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nCompared++;
    if (got !== exp) begin
      nMismatched++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // RAM with TB_RD_LAT-cycle read pipeline
  logic [7:0] mem [0:65535];
  logic [7:0] pipe [TB_RD_LAT];
  always @(posedge clk) begin
    pipe[0] <= bus.read_signal ? mem[bus.ramAddress] : 8'hA5;
    for (int i = 1; i < TB_RD_LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign bus.ramDataOut = pipe[TB_RD_LAT-1];

  logic [7:0]        expQ [$];
  logic [ADDR_W-1:0] readQ [$];
  int   doneSeen      = 0;
  int   validCycles   = 0;
  int   codesAccepted = 0;
  int   nExp          = 0;
  bit   stallMode     = 1'b0;
  bit   readyHigh     = 1'b1;
  bit   holdActive    = 1'b0;
  logic [7:0] heldCode;

  // code_ready driver: always-high, always-low, or 5 stalled cycles per code
  initial begin
    int stallCnt;
    stallCnt = 0;
    bus.code_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (stallMode) begin
        if (bus.code_valid && !bus.code_ready) begin
          stallCnt++;
          if (stallCnt > 5) begin
            bus.code_ready = 1'b1;
            stallCnt = 0;
          end
        end else begin
          bus.code_ready = 1'b0;
        end
      end else begin
        bus.code_ready = readyHigh;
        stallCnt = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (bus.read_signal) readQ.push_back(bus.ramAddress);
    if (done) begin
      doneSeen++;
      check("done_after_last_code", expQ.size(), 0);
    end
    if (bus.code_valid) begin
      validCycles++;
      if (holdActive) check("code_held_stable", bus.code, heldCode);
      if (bus.code_ready) begin
        codesAccepted++;
        holdActive = 1'b0;
        if (expQ.size() > 0) check("code_value", bus.code, expQ.pop_front());
      end else begin
        holdActive = 1'b1;
        heldCode   = bus.code;
      end
    end else begin
      holdActive = 1'b0;
    end
  end

  task automatic runTest(input logic [ADDR_W-1:0] addr, input int nbits, input bit stall);
    int         runLen = 0;
    bit         runBit = 1'b0;
    bit         b;
    logic [7:0] byteVal;
    int         nBytes;
    int         doneBefore;
    expQ.delete();
    readQ.delete();
    codesAccepted = 0;
    validCycles   = 0;
    for (int i = 0; i < nbits; i++) begin
      byteVal = mem[ADDR_W'(addr + i / 8)];
      b = byteVal[7 - (i % 8)];
      if (runLen == 0) begin
        runBit = b;
        runLen = 1;
      end else if (b == runBit && runLen < MAX_RUN) begin
        runLen++;
      end else begin
        expQ.push_back({~runBit, 7'(runLen)});
        runBit = b;
        runLen = 1;
      end
    end
    if (runLen > 0) expQ.push_back({~runBit, 7'(runLen)});
    nExp       = expQ.size();
    nBytes     = (nbits + 7) / 8;
    stallMode  = stall;
    readyHigh  = 1'b1;
    doneBefore = doneSeen;
    @(posedge clk); #1;
    start = 1'b1; startByte = addr; numBits = LEN_W'(nbits);
    @(posedge clk); #1;
    start = 1'b0;
    if (nbits > 0) check("busy_after_start", busy, 1);
    for (int c = 0; c < 20000 && doneSeen == doneBefore; c++) @(posedge clk);
    check("done_count", doneSeen - doneBefore, 1);
    @(negedge clk);
    check("busy_after_done", busy, 0);
    check("codes_accepted", codesAccepted, nExp);
    check("read_count", readQ.size(), nBytes);
    for (int k = 0; k < nBytes && k < readQ.size(); k++)
      check("read_addr", readQ[k], ADDR_W'(addr + k));
  endtask

  initial begin
    int doneBefore;
    for (int a = 0; a < 65536; a++) mem[a] = 8'h00;
    mem[16'h0010] = 8'h0F;
    mem[16'h0020] = 8'hFF;
    mem[16'h0021] = 8'h00;
    for (int a = 16'h0200; a < 16'h0300; a++) begin
      case ($urandom_range(0, 2))
        0:       mem[a] = 8'h00;
        1:       mem[a] = 8'hFF;
        default: mem[a] = 8'($urandom);
      endcase
    end
    mem[16'hFFFF] = 8'hF3;
    mem[16'h0000] = 8'h3C;
    mem[16'h0001] = 8'hE1;

    start = 1'b0; startByte = '0; numBits = '0;
    RST = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_code_valid", bus.code_valid, 0);
    check("rst_read_signal", bus.read_signal, 0);
    check("rst_ram_address", bus.ramAddress, 0);
    check("rst_code", bus.code, 0);
    RST = 1'b0;

    runTest(16'h0010, 8, 1'b0);
`ifdef COMPRESS_STATS_EN
    check("stat_code_count", codeCount, 2);
    check("stat_byte_count", byteCount, 1);
`endif
    runTest(16'h0020, 12, 1'b0);
    runTest(16'h0100, 200, 1'b0);
    runTest(16'h0010, 8, 1'b1);

    // numBits = 0: done one cycle after the sampling cycle, nothing read or emitted
    readQ.delete();
    expQ.delete();
    validCycles = 0;
    doneBefore  = doneSeen;
    @(posedge clk); #1;
    start = 1'b1; startByte = 16'h0040; numBits = '0;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("zero_done_pulse", done, 1);
    check("zero_busy", busy, 0);
    @(negedge clk);
    check("zero_done_one_cycle", done, 0);
    repeat (3) @(posedge clk);
    check("zero_done_count", doneSeen - doneBefore, 1);
    check("zero_reads", readQ.size(), 0);
    check("zero_valid_cycles", validCycles, 0);

    for (int t = 0; t < 4; t++)
      runTest(ADDR_W'(16'h0200 + $urandom_range(0, 64)), $urandom_range(1, 150), 1'($urandom_range(0, 1)));
    runTest(16'hFFFF, 20, 1'b0);

    // reset while a code is waiting in EMIT
    expQ.delete();
    stallMode = 1'b0;
    readyHigh = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; startByte = 16'h0010; numBits = LEN_W'(8);
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 0; c < 100 && bus.code_valid !== 1'b1; c++) @(negedge clk);
    check("rst_mid_reached_emit", bus.code_valid, 1);
    doneBefore = doneSeen;
    #2;
    RST = 1'b1;
    #1;
    check("rst_mid_code_valid", bus.code_valid, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_read_signal", bus.read_signal, 0);
    @(posedge clk); #1;
    RST = 1'b0;
    repeat (3) @(posedge clk);
    check("rst_mid_no_done", doneSeen - doneBefore, 0);
    runTest(16'h0010, 8, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/compress_handler.md
Name: compress_handler

Overview:
- Run-length encoder; the transmit-side counterpart of the decompress path.
- Reads a packed bitstream from RAM through the DMA read port, MSB-first within each byte, starting at a given byte address.
- Emits one code byte per bit run on a valid/ready stream; the code format is exactly what the decompressor consumes.
- Sits between the DMA module and the compressed-output link.

Parameters:
- ADDR_W, 16, RAM byte-address width
- LEN_W, 16, width of the bit-count input
- RD_LAT, 1, cycles from read_signal high to ramDataOut valid (1..4)
- MAX_RUN, 127, longest run per code; must be at most 127

Ports:
- clk  in  1  system clock, rising edge
- RST  in  1  asynchronous active-high reset
- start  in  1  one-cycle request; sampled only in IDLE
- startByte  in  ADDR_W  byte address of the first source bit (bit 7 of that byte)
- numBits  in  LEN_W  total bits to encode; latched at start
- ramAddress  out  ADDR_W  DMA read address
- read_signal  out  1  DMA read strobe, high for exactly 1 cycle per byte
- ramDataOut  in  8  DMA read data, valid RD_LAT cycles after the strobe
- code  out  8  code[7]=1 means a run of 0s, code[7]=0 means a run of 1s; code[6:0]=run length 1..MAX_RUN
- code_valid  out  1  code is held stable while code_valid=1 and code_ready=0
- code_ready  in  1  consumer accepts code when code_valid & code_ready
- busy  out  1  high from the cycle after start until done
- done  out  1  one-cycle pulse after the last code is accepted

Behaviour:
- Reset (asynchronous): state IDLE; all outputs 0; counters, address and shift register cleared.
- FSM states: IDLE, FETCH, WAIT, SCAN, EMIT, FIN.
- IDLE:
  - start=1 and numBits>0: latch startByte/numBits, clear run, go FETCH.
  - start=1 and numBits=0: go FIN (no codes).
- FETCH: drive ramAddress = current byte address, read_signal=1 for one cycle, go WAIT.
- WAIT: count RD_LAT cycles; on the last one capture ramDataOut into an 8-bit shift register, go SCAN.
- SCAN: consume one bit per cycle, bit 7 first, and decrement the remaining-bit counter.
  - First bit of the stream: runBit = bit, runLen = 1.
  - Bit equal to runBit and runLen < MAX_RUN: runLen++.
  - Bit differs, or runLen = MAX_RUN: go EMIT with the current run and hold the new bit pending; it starts the next run with runLen=1 after the emit.
  - Last bit consumed (counter reaches 0): go EMIT, then FIN.
  - All 8 bits of the byte consumed with bits remaining: address+1, go FETCH. The run carries across byte boundaries.
- EMIT:
  - code = {~runBit, runLen[6:0]}, code_valid=1.
  - Stay until code_ready=1; code_valid drops the next cycle. Scanning is stalled meanwhile.
  - code_ready may be high before code_valid; the transfer then completes in the first valid cycle.
- FIN: done=1 for one cycle, busy=0, return to IDLE.
- Latency:
  - First code valid no earlier than 2+RD_LAT+runLen cycles after start.
  - Throughput: 1 bit per cycle, plus 1+RD_LAT cycles per byte fetch and 1 cycle per code with code_ready held high.
- Widths: ramAddress wraps modulo 2^ADDR_W. runLen never exceeds MAX_RUN, and a code with length 0 is never emitted.
- Partial last byte: unused low bits are ignored and never read past numBits.
- start while busy: ignored.
- RST mid-operation: immediate return to IDLE. A pending code is dropped, code_valid goes low, and no done pulse is produced.

Optional Feature:
- Macro COMPRESS_STATS_EN.
- Defined: adds output ports codeCount[15:0] and byteCount[ADDR_W-1:0].
  - Both clear at start and at RST.
  - codeCount increments on each accepted code; byteCount increments on each read_signal.
  - Both hold their values after done until the next start.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- RAM[0x0010]=0x0F, start with startByte=0x0010, numBits=8, code_ready=1 -> codes 0x84 then 0x04; exactly one read at 0x0010; done pulse; busy low afterward.
- RAM[0x0020..0x0021]=0xFF,0x00, numBits=12 -> codes 0x08 then 0x84; reads at 0x0020 and 0x0021 only; the run crosses the byte boundary correctly.
- 25 bytes of 0x00 (200 zeros), numBits=200 -> codes 0xFF then 0xC9 (127+73); 25 reads.
- Same stimulus as the 0x0F case with code_ready low for 5 cycles per code -> code held stable while valid; same code sequence; no bit lost; done only after the second accept.
- numBits=0 -> no read_signal, no code_valid, done pulse one cycle after the IDLE cycle that sampled start.
- RST asserted while in EMIT with code_valid high -> code_valid, busy, read_signal go 0 immediately; no done; a later start encodes correctly from scratch.
